// File: rtl/tt_um_matmul_operand_loader.sv
// Operand loader for the 2x2 matrix multiplier tile: validates 2-bit elements,
// fills a shadow buffer and publishes packed A/B words atomically on commit.
module tt_um_matmul_operand_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_FULL    = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic [15:0] shadow_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [2:0]  prev_q;

    logic [1:0]  elem;
    logic [2:0]  rise;
    logic        wr_ev;
    logic        commit_ev;
    logic        clear_ev;
    logic        loading;
    logic        unused_ok;

    assign elem      = ui_in[1:0];
    assign rise      = ui_in[4:2] & ~prev_q;
    assign wr_ev     = ena & rise[0];
    assign commit_ev = ena & rise[1];
    assign clear_ev  = ena & rise[2];
    assign loading   = (state_q == S_EMPTY) || (state_q == S_FILLING);
    assign unused_ok = &{1'b0, uio_in, ui_in[7:5]};

    assign uo_out  = a_q;
    assign uio_out = b_q;
    assign uio_oe  = ena ? 8'hFF : 8'h00;

    // Strobe history runs even while disabled, so edges during ena=0 are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 3'b111;
        end else begin
            prev_q <= ui_in[4:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_EMPTY;
            count_q  <= 4'd0;
            shadow_q <= 16'h0000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
        end else if (clear_ev) begin
            state_q  <= S_EMPTY;
            count_q  <= 4'd0;
            shadow_q <= 16'h0000;
        end else if (commit_ev) begin
            if (state_q == S_FULL || state_q == S_ERROR) begin
                a_q      <= (state_q == S_FULL) ? shadow_q[7:0]  : 8'h00;
                b_q      <= (state_q == S_FULL) ? shadow_q[15:8] : 8'h00;
                state_q  <= S_EMPTY;
                count_q  <= 4'd0;
                shadow_q <= 16'h0000;
            end
        end else if (wr_ev && loading) begin
            if (elem == 2'd3) begin
                state_q <= S_ERROR;
            end else begin
                shadow_q[{count_q[2:0], 1'b0} +: 2] <= elem;
                count_q <= count_q + 4'd1;
                state_q <= (count_q == 4'd7) ? S_FULL : S_FILLING;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_matmul_operand_loader.sv
// Directed bench for the matmul operand loader.
module tb_tt_um_matmul_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int passed = 0;
    int total  = 0;

    tt_um_matmul_operand_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [2:0] s, input logic [1:0] v);
        ui_in = {3'b000, s, v};
        @(negedge clk);
        ui_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] v);
        pulse(3'b001, v);
    endtask

    task automatic commit();
        pulse(3'b010, 2'd0);
    endtask

    task automatic load8(input logic [15:0] vals);
        logic [15:0] t;
        t = vals;
        for (int i = 0; i < 8; i++) wr(t[2*i +: 2]);
    endtask

    task automatic check_ab(input string tag, input logic [7:0] ea,
                            input logic [7:0] eb);
        check({tag, "_a"}, uo_out, ea);
        check({tag, "_b"}, uio_out, eb);
    endtask

    // Element lists packed index 0 at [1:0]
    localparam logic [15:0] L1 = 16'h1A49; // 1,2,0,1,2,2,1,0
    localparam logic [15:0] L2 = 16'hAAAA; // all 2
    localparam logic [15:0] L5 = 16'h5555; // all 1
    localparam logic [15:0] L6 = 16'hAA00; // 0,0,0,0,2,2,2,2

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #12;
        check_ab("reset", 8'h00, 8'h00);
        check("oe_on", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load8(L1);
        commit();
        check_ab("load1", 8'h49, 8'h1A);
        commit();
        check_ab("recommit", 8'h49, 8'h1A);

        wr(0); wr(1); wr(2); wr(1); wr(0);
        commit();
        check_ab("partial", 8'h49, 8'h1A);
        wr(0); wr(1); wr(2);
        commit();
        check_ab("complete", 8'h64, 8'h90);

        wr(2); wr(1); wr(3);
        check_ab("err_hold", 8'h64, 8'h90);
        wr(2);
        commit();
        check_ab("err_commit", 8'h00, 8'h00);
        load8(L1);
        commit();
        check_ab("after_err", 8'h49, 8'h1A);

        load8(L2);
        wr(1);
        commit();
        check_ab("ninth", 8'hAA, 8'hAA);

        load8(L1);
        commit();
        check_ab("prior", 8'h49, 8'h1A);
        load8(L2);
        pulse(3'b110, 2'd0);
        check_ab("clr_cmt", 8'h49, 8'h1A);
        commit();
        check_ab("empty_cmt", 8'h49, 8'h1A);
        load8(L5);
        commit();
        check_ab("post_clear", 8'h55, 8'h55);

        wr(2); wr(2); wr(2);
        ui_in = 8'h06;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_ab("async_rst", 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ui_in = 8'h00;
        @(negedge clk);
        check_ab("rst_rel", 8'h00, 8'h00);
        load8(L5);
        commit();
        check_ab("held_wr", 8'h55, 8'h55);

        ena = 1'b0;
        #1;
        check("oe_off", uio_oe, 8'h00);
        @(negedge clk);
        load8(L1);
        commit();
        check_ab("ena_off", 8'h55, 8'h55);
        ena = 1'b1;
        #1;
        check("oe_back", uio_oe, 8'hFF);
        @(negedge clk);
        commit();
        check_ab("ena_empty", 8'h55, 8'h55);
        load8(L6);
        commit();
        check_ab("ena_load", 8'h00, 8'hAA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
